// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line scheduler: slot table,
// transparency code and controller states.
package sprite_pkg;

  localparam int         NUM_SLOTS   = 8;
  localparam int         SLOT_IDX_W  = $clog2(NUM_SLOTS);
  localparam logic [5:0] TRANSPARENT = 6'd63;

  typedef enum logic [1:0] {
    KIND_SAMUS   = 2'd0,
    KIND_MONSTER = 2'd1,
    KIND_POWERUP = 2'd2,
    KIND_BULLET  = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FETCH = 2'd2,
    WRITE = 2'd3
  } state_e;

  // Fixed slot assignment: 0 samus, 1-3 monsters, 4 power-up, 5-7 bullets.
  function automatic kind_e slot_kind(input logic [SLOT_IDX_W-1:0] slot);
    kind_e k;
    case (slot)
      3'd0:                k = KIND_SAMUS;
      3'd1, 3'd2, 3'd3:    k = KIND_MONSTER;
      3'd4:                k = KIND_POWERUP;
      default:             k = KIND_BULLET;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Sprite ROM fetch handshake and line-buffer write port of the scheduler.
interface sprite_line_scheduler_if;
  logic        rom_req;
  logic [16:0] rom_addr;
  logic        rom_ack;
  logic [5:0]  rom_data;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [5:0]  lb_data;

  modport master (
    output rom_req, rom_addr, lb_we, lb_addr, lb_data,
    input  rom_ack, rom_data
  );

  modport slave (
    input  rom_req, rom_addr, lb_we, lb_addr, lb_data,
    output rom_ack, rom_data
  );
endinterface

// File: rtl/sprite_slot_hit.sv
// Vertical hit test for the currently selected slot plus sprite ROM
// address formation {kind, frame, row, col}.
module sprite_slot_hit
  import sprite_pkg::*;
#(
  parameter int SPRITE_H = 70
) (
  input  logic        en,
  input  logic [10:0] slot_y,
  input  logic [10:0] line_y,
  input  kind_e       kind,
  input  logic [1:0]  num,
  input  logic [6:0]  row,
  input  logic [5:0]  col,
  output logic        hit,
  output logic [6:0]  hit_row,
  output logic [16:0] addr
);

  logic [11:0] top;
  logic [11:0] bottom;
  logic [11:0] ly;

  // Widened by one bit so a sprite near the bottom of the range never wraps.
  always_comb begin
    top     = {1'b0, slot_y};
    bottom  = top + 12'(SPRITE_H);
    ly      = {1'b0, line_y};
    hit     = en && (ly >= top) && (ly < bottom);
    hit_row = 7'(line_y - slot_y);
    addr    = {kind, num, row, col};
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Walks the eight sprite slots for one scanline, fetches visible sprite
// pixels from ROM and writes the opaque, on-screen ones into the line buffer.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 45,
  parameter int SPRITE_H = 70,
  parameter int LINE_W   = 640
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     line_start,
  input  logic [10:0]              line_y,
  input  logic [NUM_SLOTS-1:0]     slot_en,
  input  logic [NUM_SLOTS*11-1:0]  slot_x,
  input  logic [NUM_SLOTS*11-1:0]  slot_y,
  input  logic [NUM_SLOTS*2-1:0]   slot_num,
  sprite_line_scheduler_if.master  bus,
  output logic                     busy,
  output logic                     line_done,
  output logic                     overrun
);

  state_e                state_q, state_d;
  logic [SLOT_IDX_W-1:0] slot_q, slot_d;
  logic [10:0]           line_y_q, line_y_d;
  logic [6:0]            row_q, row_d;
  logic [5:0]            col_q, col_d;
  logic [5:0]            data_q, data_d;
  logic [11:0]           x_q, x_d;
  logic                  line_done_q, line_done_d;
  logic                  overrun_q, overrun_d;

  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic [1:0]  cur_num;
  logic        cur_en;
  logic        hit;
  logic [6:0]  hit_row;
  logic [16:0] addr;
  logic        last_col;

  always_comb begin
    cur_x   = slot_x[int'(slot_q)*11 +: 11];
    cur_y   = slot_y[int'(slot_q)*11 +: 11];
    cur_num = slot_num[int'(slot_q)*2 +: 2];
    cur_en  = slot_en[slot_q];
  end

  sprite_slot_hit #(.SPRITE_H(SPRITE_H)) u_hit (
    .en      (cur_en),
    .slot_y  (cur_y),
    .line_y  (line_y_q),
    .kind    (slot_kind(slot_q)),
    .num     (cur_num),
    .row     (row_q),
    .col     (col_q),
    .hit     (hit),
    .hit_row (hit_row),
    .addr    (addr)
  );

  assign last_col = (col_q == 6'(SPRITE_W - 1));

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    line_y_d    = line_y_q;
    row_d       = row_q;
    col_d       = col_q;
    data_d      = data_q;
    x_d         = x_q;
    line_done_d = 1'b0;
    overrun_d   = overrun_q;

    // A new request always wins; arriving mid-line it aborts the old line.
    if (line_start) begin
      if (state_q != IDLE) overrun_d = 1'b1;
      line_y_d = line_y;
      slot_d   = SLOT_IDX_W'(NUM_SLOTS - 1);
      state_d  = SCAN;
    end else begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            row_d   = hit_row;
            col_d   = '0;
            state_d = FETCH;
          end else if (slot_q == '0) begin
            line_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            slot_d = slot_q - 1'b1;
          end
        end
        FETCH: begin
          if (bus.rom_ack) begin
            data_d  = bus.rom_data;
            x_d     = 12'(cur_x) + 12'(col_q);
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (!last_col) begin
            col_d   = col_q + 1'b1;
            state_d = FETCH;
          end else if (slot_q == '0) begin
            line_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            slot_d  = slot_q - 1'b1;
            state_d = SCAN;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      line_y_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      data_q      <= '0;
      x_q         <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      line_y_q    <= line_y_d;
      row_q       <= row_d;
      col_q       <= col_d;
      data_q      <= data_d;
      x_q         <= x_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Address and write buses are held at zero whenever they are not qualified.
  always_comb begin
    bus.rom_req  = (state_q == FETCH);
    bus.rom_addr = bus.rom_req ? addr : '0;
    bus.lb_we    = (state_q == WRITE) && (data_q != TRANSPARENT) && (x_q < 12'(LINE_W));
    bus.lb_addr  = bus.lb_we ? x_q[9:0] : '0;
    bus.lb_data  = bus.lb_we ? data_q : '0;
    busy         = (state_q != IDLE);
    line_done    = line_done_q;
    overrun      = overrun_q;
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench: a sprite-level reference model predicts line-buffer
// writes; a ROM responder with random latency and a monitor check the DUT.
module tb_sprite_line_scheduler;
  import sprite_pkg::*;

  localparam int SPRITE_W = 45;
  localparam int SPRITE_H = 70;
  localparam int LINE_W   = 640;
  localparam int BUDGET   = 20000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        line_start = 1'b0;
  logic [10:0] line_y = '0;
  logic [7:0]  slot_en = '0;
  logic [87:0] slot_x = '0;
  logic [87:0] slot_y = '0;
  logic [15:0] slot_num = '0;
  logic        busy, line_done, overrun;
  logic        rom_ack_r = 1'b0;
  logic [5:0]  rom_data_r = '0;

  sprite_line_scheduler_if bus ();
  assign bus.rom_ack  = rom_ack_r;
  assign bus.rom_data = rom_data_r;

  sprite_line_scheduler #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .LINE_W(LINE_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .line_start (line_start),
    .line_y     (line_y),
    .slot_en    (slot_en),
    .slot_x     (slot_x),
    .slot_y     (slot_y),
    .slot_num   (slot_num),
    .bus        (bus),
    .busy       (busy),
    .line_done  (line_done),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] addr;
    logic [5:0] data;
  } wr_t;

  logic [5:0]  rom_mem [0:131071];
  logic [5:0]  lb_mem  [0:1023];
  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          req_cycles = 0;
  int          ack_delay_max = 0;
  int          fixed_delay = 0;
  logic        force_ack = 1'b0;
  int          wait_cnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [16:0] acked_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int next_delay();
    return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(ack_delay_max, 0));
  endfunction

  // ROM responder: acknowledges a pending request after a chosen delay.
  always @(posedge Clk) begin
    #2;
    if (force_ack) begin
      rom_ack_r  = 1'b1;
      rom_data_r = 6'd7;
    end else if (rom_ack_r) begin
      rom_ack_r = 1'b0;
      wait_cnt  = next_delay();
    end else if (bus.rom_req) begin
      if (wait_cnt == 0) begin
        rom_ack_r  = 1'b1;
        rom_data_r = rom_mem[bus.rom_addr];
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = next_delay();
    end
  end

  // Monitor: compares every line-buffer write against the scoreboard.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.lb_we) begin
        wr_cnt++;
        lb_mem[bus.lb_addr] = bus.lb_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write", bus.lb_addr, bus.lb_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.lb_addr), 32'(e.addr));
          check("wr_data", 32'(bus.lb_data), 32'(e.data));
        end
      end
      if (line_done) done_cnt++;
      if (bus.rom_req) req_cycles++;
      if (prev_req && !prev_ack && bus.rom_req)
        check("rom_addr_stable", 32'(bus.rom_addr), 32'(prev_addr));
      if (bus.rom_req && bus.rom_ack) acked_addr = bus.rom_addr;
    end
    prev_req  = bus.rom_req;
    prev_ack  = bus.rom_ack;
    prev_addr = bus.rom_addr;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic int kind_of(input int s);
    if (s == 0) return 0;
    if (s <= 3) return 1;
    if (s == 4) return 2;
    return 3;
  endfunction

  task automatic set_slot(input int s, input bit en, input int x, input int y, input int num);
    slot_en[s]          = en;
    slot_x[s*11 +: 11]  = 11'(x);
    slot_y[s*11 +: 11]  = 11'(y);
    slot_num[s*2 +: 2]  = 2'(num);
  endtask

  task automatic fill_rom(input int kind, input int val);
    for (int a = 0; a < 32768; a++) rom_mem[kind*32768 + a] = 6'(val);
  endtask

  // Reference model: slots low priority first, every opaque on-screen pixel.
  function automatic int build_expect(input int ly);
    int n = 0;
    for (int s = 7; s >= 0; s--) begin
      int sx  = int'(slot_x[s*11 +: 11]);
      int sy  = int'(slot_y[s*11 +: 11]);
      int num = int'(slot_num[s*2 +: 2]);
      if (slot_en[s] && ly >= sy && ly < sy + SPRITE_H) begin
        int row = ly - sy;
        for (int c = 0; c < SPRITE_W; c++) begin
          int a = kind_of(s)*32768 + num*8192 + row*64 + c;
          int d = int'(rom_mem[a]);
          int x = sx + c;
          if (d != 63 && x < LINE_W) begin
            exp_q.push_back('{addr: 10'(x), data: 6'(d)});
            n++;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL line_timeout: line_done not seen within %0d cycles", BUDGET);
    end
    tick(2);
    check("line_done_once", 32'(done_cnt - d0), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.rom_req && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: rom_req never asserted");
    end
  endtask

  task automatic run_line(input string name, input int ly, output int nwr);
    int w0 = wr_cnt;
    int d0 = done_cnt;
    int n_exp;
    line_y     = 11'(ly);
    n_exp      = build_expect(ly);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_done(d0);
    nwr = wr_cnt - w0;
    check(name, 32'(nwr), 32'(n_exp));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rom_req"},   32'(bus.rom_req),  32'd0);
    check({tag, "_rom_addr"},  32'(bus.rom_addr), 32'd0);
    check({tag, "_lb_we"},     32'(bus.lb_we),    32'd0);
    check({tag, "_lb_addr"},   32'(bus.lb_addr),  32'd0);
    check({tag, "_lb_data"},   32'(bus.lb_data),  32'd0);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_line_done"}, 32'(line_done),    32'd0);
    check({tag, "_overrun"},   32'(overrun),      32'd0);
  endtask

  initial begin
    int nwr, r0, w0, d0;
    fill_rom(0, 5); fill_rom(1, 5); fill_rom(2, 5); fill_rom(3, 5);
    tick(3);
    check_idle_outputs("reset");
    Reset = 1'b0;
    tick();

    // Single samus sprite, constant data, immediate ack.
    set_slot(0, 1, 100, 50, 0);
    run_line("samus_writes", 60, nwr);
    check("samus_count", 32'(nwr), 32'd45);
    check("samus_row", 32'(acked_addr[12:6]), 32'd10);
    check("samus_lb_first", 32'(lb_mem[100]), 32'd5);
    check("samus_lb_last", 32'(lb_mem[144]), 32'd5);

    // Overlap: slot 2 written first, samus overwrites.
    fill_rom(1, 58);
    slot_en = '0;
    set_slot(0, 1, 200, 0, 0);
    set_slot(2, 1, 200, 0, 0);
    run_line("overlap_writes", 0, nwr);
    check("overlap_count", 32'(nwr), 32'd90);
    check("overlap_lb_200", 32'(lb_mem[200]), 32'd5);
    check("overlap_lb_222", 32'(lb_mem[222]), 32'd5);
    check("overlap_lb_244", 32'(lb_mem[244]), 32'd5);

    // Transparent leading columns.
    slot_en = '0;
    set_slot(0, 1, 100, 50, 0);
    for (int c = 0; c < 10; c++) rom_mem[10*64 + c] = 6'd63;
    run_line("transp_writes", 60, nwr);
    check("transp_count", 32'(nwr), 32'd35);
    fill_rom(0, 5);

    // Right-edge clipping, then a line just below the sprite.
    set_slot(0, 1, 620, 50, 0);
    run_line("clip_writes", 60, nwr);
    check("clip_count", 32'(nwr), 32'd20);
    set_slot(0, 1, 100, 0, 0);
    r0 = req_cycles;
    run_line("miss_writes", 70, nwr);
    check("miss_no_req", 32'(req_cycles - r0), 32'd0);

    // Abort mid-FETCH with a slow ROM.
    fixed_delay = 5;
    set_slot(0, 1, 100, 50, 0);
    d0 = done_cnt;
    line_y = 11'd60;
    void'(build_expect(60));
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_req();
    tick(2);
    exp_q.delete();
    line_y = 11'd61;
    void'(build_expect(61));
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("abort_overrun", 32'(overrun), 32'd1);
    check("abort_req_drop", 32'(bus.rom_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    wait_done(d0);
    check("abort_row", 32'(acked_addr[12:6]), 32'd11);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset wins over a simultaneous line_start.
    Reset = 1'b1;
    line_start = 1'b1;
    tick();
    Reset = 1'b0;
    line_start = 1'b0;
    tick();
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_overrun", 32'(overrun), 32'd0);

    // Reset during FETCH followed by a late ack.
    fixed_delay = 20;
    line_y = 11'd60;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_req();
    w0 = wr_cnt;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_fetch_req_drop", 32'(bus.rom_req), 32'd0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick(2);
    check_idle_outputs("rst_fetch");
    check("rst_fetch_no_write", 32'(wr_cnt - w0), 32'd0);

    // Randomised lines against the reference model.
    fixed_delay   = -1;
    ack_delay_max = 3;
    for (int a = 0; a < 131072; a++)
      rom_mem[a] = ($urandom_range(7, 0) == 0) ? 6'd63 : 6'($urandom_range(62, 0));
    for (int t = 0; t < 8; t++) begin
      int ly = int'($urandom_range(600, 0));
      for (int s = 0; s < 8; s++) begin
        int y = ly - int'($urandom_range(90, 0));
        if (y < 0) y = 0;
        set_slot(s, bit'($urandom_range(1, 0)), int'($urandom_range(700, 0)), y,
                 int'($urandom_range(3, 0)));
      end
      run_line("rand_writes", ly, nwr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
